// File: rtl/sl_reg_responder.sv
// ============================================================================
//  Module      : sl_reg_responder
//  Description : Peripheral-side responder for an SL811-style indexed bus.
//                Address register, auto-incrementing register file and an
//                interrupt status/enable pair driving intrq. Bus strobes are
//                asynchronous and synchronised into fclk.
//                Optional macro SL_AUTOINC_EN: data accesses post-increment
//                the address register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sl_reg_responder #(
  parameter int                ADDR_W        = 4,
  parameter logic [ADDR_W-1:0] INT_EN_ADDR   = 4'h6,
  parameter logic [ADDR_W-1:0] INT_STAT_ADDR = 4'hD
) (
  input  logic       fclk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       a0,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic [7:0] irq_evt,
  output logic       intrq
);

  localparam int                DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

`ifdef SL_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  logic              rd_act, wr_act;
  logic              rd_s1, rd_s2, rd_s3;
  logic              wr_s1, wr_s2, wr_s3;
  logic              a0_s1, a0_s2;
  logic [1:0]        settle;
  logic              armed;
  state_t            state, next_state;
  logic              commit_wr, rd_done;
  logic              acc_a0;
  logic [7:0]        wdata;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        regs [DEPTH];
  logic [7:0]        status, enable;
  logic [7:0]        status_clr;
  logic [7:0]        rd_sel;
  logic              rd_rise, rd_fall, wr_rise, wr_fall;
  logic              hit_stat, hit_en;

  assign rd_act = ~cs_n & ~rd_n;
  assign wr_act = ~cs_n & ~wr_n;

  // Tristate enable follows the raw strobes so the bus is driven immediately.
  assign d_oe = ~cs_n & ~rd_n & rst_n;

  // Two-flop synchronisers plus a third stage for edge detection.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      rd_s1 <= 1'b0; rd_s2 <= 1'b0; rd_s3 <= 1'b0;
      wr_s1 <= 1'b0; wr_s2 <= 1'b0; wr_s3 <= 1'b0;
      a0_s1 <= 1'b0; a0_s2 <= 1'b0;
    end else begin
      rd_s1 <= rd_act; rd_s2 <= rd_s1; rd_s3 <= rd_s2;
      wr_s1 <= wr_act; wr_s2 <= wr_s1; wr_s3 <= wr_s2;
      a0_s1 <= a0;     a0_s2 <= a0_s1;
    end
  end

  assign rd_rise = rd_s2 & ~rd_s3;
  assign rd_fall = ~rd_s2 & rd_s3;
  assign wr_rise = wr_s2 & ~wr_s3;
  assign wr_fall = ~wr_s2 & wr_s3;

  // Arm only once the synchronisers have refilled after reset and show an
  // idle bus; the reset values of s2 say nothing about the real bus state.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      settle <= 2'b00;
      armed  <= 1'b0;
    end else begin
      settle <= {settle[0], 1'b1};
      armed  <= armed | (settle[1] & ~rd_s2 & ~wr_s2);
    end
  end

  // State register; the a0 phase is captured when an access starts.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc_a0 <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && next_state != IDLE) acc_a0 <= a0_s2;
    end
  end

  // Next-state logic; simultaneous read and write abandons the access.
  always_comb begin
    next_state = state;
    commit_wr  = 1'b0;
    rd_done    = 1'b0;
    if (rd_s2 && wr_s2) begin
      next_state = IDLE;
    end else if (armed) begin
      case (state)
        IDLE: begin
          if (rd_rise)      next_state = RD;
          else if (wr_rise) next_state = WR;
        end
        RD: begin
          if (rd_fall) begin
            next_state = IDLE;
            rd_done    = 1'b1;
          end
        end
        WR: begin
          if (wr_fall) begin
            next_state = IDLE;
            commit_wr  = 1'b1;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Write data tracks the bus while the synchronised write strobe is active.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) wdata <= 8'h00;
    else if (wr_s1) wdata <= d_in;
  end

  assign hit_stat = commit_wr & acc_a0 & (addr == INT_STAT_ADDR);
  assign hit_en   = commit_wr & acc_a0 & (addr == INT_EN_ADDR);

  // Address register and register file updates on access completion.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= 8'h00;
    end else if (commit_wr) begin
      if (!acc_a0) begin
        addr <= wdata[ADDR_W-1:0];
      end else begin
        regs[addr] <= wdata;
        if (AUTOINC) addr <= addr + ADDR_ONE;
      end
    end else if (rd_done && acc_a0 && AUTOINC) begin
      addr <= addr + ADDR_ONE;
    end
  end

  assign status_clr = hit_stat ? wdata : 8'h00;

  // Interrupt status (set wins over clear), enable, and registered request.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      status <= 8'h00;
      enable <= 8'h00;
      intrq  <= 1'b0;
    end else begin
      status <= (status & ~status_clr) | irq_evt;
      if (hit_en) enable <= wdata;
      intrq <= |(status & enable);
    end
  end

  // Read source selection; interrupt registers shadow their file entries.
  always_comb begin
    rd_sel = regs[addr];
    if (addr == INT_STAT_ADDR)    rd_sel = status;
    else if (addr == INT_EN_ADDR) rd_sel = enable;
  end

  // Read data is refreshed every cycle from the synchronised a0 phase.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) d_out <= 8'h00;
    else        d_out <= a0_s2 ? rd_sel : 8'(addr);
  end

endmodule

`default_nettype wire

// File: tb/tb_sl_reg_responder.sv
// ============================================================================
//  Module      : tb_sl_reg_responder
//  Description : Directed self-checking bench for sl_reg_responder.
//                Expectations depend on SL_AUTOINC_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sl_reg_responder;

  logic       fclk = 1'b0;
  logic       rst_n;
  logic       cs_n, a0, rd_n, wr_n;
  logic [7:0] d_in, d_out, irq_evt;
  logic       d_oe, intrq;
  logic [7:0] rv;
  int         total = 0;
  int         bad   = 0;

`ifdef SL_AUTOINC_EN
  localparam logic [7:0] E_ADDR_AFTER_WR = 8'h05;
  localparam logic [7:0] E_RD0           = 8'h5A;
  localparam logic [7:0] E_RD1           = 8'hA5;
  localparam logic [7:0] E_ADDR_AFTER_RD = 8'h05;
  localparam logic [7:0] E_REG4          = 8'hA5;
  localparam logic [7:0] E_WRAP_ADDR     = 8'h00;
`else
  localparam logic [7:0] E_ADDR_AFTER_WR = 8'h03;
  localparam logic [7:0] E_RD0           = 8'hA5;
  localparam logic [7:0] E_RD1           = 8'hA5;
  localparam logic [7:0] E_ADDR_AFTER_RD = 8'h03;
  localparam logic [7:0] E_REG4          = 8'h00;
  localparam logic [7:0] E_WRAP_ADDR     = 8'h0F;
`endif

  sl_reg_responder dut (
    .fclk   (fclk),
    .rst_n  (rst_n),
    .cs_n   (cs_n),
    .a0     (a0),
    .rd_n   (rd_n),
    .wr_n   (wr_n),
    .d_in   (d_in),
    .d_out  (d_out),
    .d_oe   (d_oe),
    .irq_evt(irq_evt),
    .intrq  (intrq)
  );

  always #10 fclk = ~fclk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 3 ns past the edge.
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge fclk);
    #3;
  endtask

  task automatic bus_write(input logic a, input logic [7:0] v);
    cs_n = 1'b0; a0 = a; d_in = v;
    wait_cyc(1);
    wr_n = 1'b0;
    wait_cyc(6);
    wr_n = 1'b1;
    wait_cyc(2);
    cs_n = 1'b1;
    wait_cyc(4);
  endtask

  task automatic bus_read(input logic a, output logic [7:0] v);
    cs_n = 1'b0; a0 = a;
    wait_cyc(1);
    rd_n = 1'b0;
    wait_cyc(6);
    v = d_out;
    check("d_oe_during_read", {7'b0, d_oe}, 8'h01);
    rd_n = 1'b1;
    wait_cyc(2);
    cs_n = 1'b1;
    wait_cyc(4);
  endtask

  initial begin
    rst_n = 1'b0; cs_n = 1'b1; a0 = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
    d_in = 8'h00; irq_evt = 8'h00;

    // Reset state
    wait_cyc(3);
    check("rst_d_out", d_out, 8'h00);
    check("rst_d_oe", {7'b0, d_oe}, 8'h00);
    check("rst_intrq", {7'b0, intrq}, 8'h00);
    rst_n = 1'b1;
    wait_cyc(4);
    bus_read(1'b0, rv);
    check("rst_addr", rv, 8'h00);
    check("d_oe_idle", {7'b0, d_oe}, 8'h00);

    // Write/read sequence
    bus_write(1'b0, 8'h03);
    bus_write(1'b1, 8'h5A);
    bus_write(1'b1, 8'hA5);
    bus_read(1'b0, rv);
    check("addr_after_wr", rv, E_ADDR_AFTER_WR);
    bus_write(1'b0, 8'h03);
    bus_read(1'b1, rv);
    check("rd_first", rv, E_RD0);
    bus_read(1'b1, rv);
    check("rd_second", rv, E_RD1);
    bus_read(1'b0, rv);
    check("addr_after_rd", rv, E_ADDR_AFTER_RD);
    bus_write(1'b0, 8'h04);
    bus_read(1'b1, rv);
    check("reg4", rv, E_REG4);

    // Address wrap
    bus_write(1'b0, 8'h0F);
    bus_write(1'b1, 8'h11);
    bus_read(1'b0, rv);
    check("wrap_addr", rv, E_WRAP_ADDR);
    bus_write(1'b0, 8'h0F);
    bus_read(1'b1, rv);
    check("reg15", rv, 8'h11);

    // Interrupt enable
    bus_write(1'b0, 8'h06);
    bus_write(1'b1, 8'h03);
    bus_write(1'b0, 8'h06);
    bus_read(1'b1, rv);
    check("enable_rb", rv, 8'h03);

    // Event pulse -> intrq two cycles later
    irq_evt = 8'h01;
    @(posedge fclk); #1;
    check("intrq_lat1", {7'b0, intrq}, 8'h00);
    #2 irq_evt = 8'h00;
    @(posedge fclk); #1;
    check("intrq_lat2", {7'b0, intrq}, 8'h01);
    #2;

    // Write-1-to-clear status
    bus_write(1'b0, 8'h0D);
    bus_write(1'b1, 8'h01);
    wait_cyc(2);
    check("intrq_cleared", {7'b0, intrq}, 8'h00);
    bus_write(1'b0, 8'h0D);
    bus_read(1'b1, rv);
    check("status_cleared", rv, 8'h00);

    // Set wins over simultaneous clear
    irq_evt = 8'h01;
    wait_cyc(1);
    irq_evt = 8'h00;
    wait_cyc(3);
    check("intrq_reset", {7'b0, intrq}, 8'h01);
    bus_write(1'b0, 8'h0D);
    cs_n = 1'b0; a0 = 1'b1; d_in = 8'h01;
    wait_cyc(1);
    wr_n = 1'b0;
    wait_cyc(6);
    wr_n = 1'b1;
    wait_cyc(2);
    irq_evt = 8'h01;
    wait_cyc(1);
    irq_evt = 8'h00;
    wait_cyc(1);
    cs_n = 1'b1;
    wait_cyc(4);
    check("intrq_set_wins", {7'b0, intrq}, 8'h01);
    bus_write(1'b0, 8'h0D);
    bus_read(1'b1, rv);
    check("status_set_wins", rv, 8'h01);

    // Reset asserted mid-write, released with wr_n still low
    cs_n = 1'b0; a0 = 1'b1; d_in = 8'h77;
    wait_cyc(1);
    wr_n = 1'b0;
    wait_cyc(3);
    rst_n = 1'b0;
    wait_cyc(3);
    check("midrst_intrq", {7'b0, intrq}, 8'h00);
    rst_n = 1'b1;
    wait_cyc(6);
    wr_n = 1'b1;
    wait_cyc(3);
    cs_n = 1'b1;
    wait_cyc(4);
    bus_read(1'b0, rv);
    check("midrst_addr", rv, 8'h00);
    bus_read(1'b1, rv);
    check("midrst_reg0", rv, 8'h00);
    bus_write(1'b0, 8'h00);
    bus_write(1'b1, 8'h77);
    bus_write(1'b0, 8'h00);
    bus_read(1'b1, rv);
    check("post_rst_write", rv, 8'h77);

    // Illegal simultaneous read and write
    bus_write(1'b0, 8'h02);
    bus_write(1'b1, 8'h33);
    bus_write(1'b0, 8'h02);
    cs_n = 1'b0; a0 = 1'b1; d_in = 8'h99;
    wait_cyc(1);
    rd_n = 1'b0; wr_n = 1'b0;
    wait_cyc(6);
    rd_n = 1'b1; wr_n = 1'b1;
    wait_cyc(2);
    cs_n = 1'b1;
    wait_cyc(4);
    bus_read(1'b0, rv);
    check("illegal_addr", rv, 8'h02);
    bus_read(1'b1, rv);
    check("illegal_reg2", rv, 8'h33);
    bus_write(1'b0, 8'h05);
    bus_read(1'b0, rv);
    check("illegal_then_idle", rv, 8'h05);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
